// File: rtl/tx_symbol_scheduler.sv
// -----------------------------------------------------------------------------
// tx_symbol_scheduler
//
// Transmit framing scheduler. Produces a continuous 8-bit symbol stream:
// COM x4 after reset, then IDL fill, STP/SDP-framed packets from two sources
// (TLP and DLLP, round-robin), and periodic COM,SKP,SKP,SKP ordered sets.
//
// Ports:
//   clk, reset_L                  clock, asynchronous active-low reset
//   tlp_valid/data/last/ready     TLP byte source handshake
//   dllp_valid/data/last/ready    DLLP byte source handshake
//   valid, data                   registered output symbol stream
//   err_underrun                  one-cycle pulse on the END that closes a
//                                 packet whose source dropped valid mid-packet
// -----------------------------------------------------------------------------
module tx_symbol_scheduler #(
    parameter int unsigned SKP_INTERVAL = 32,
    parameter logic [7:0]  COM          = 8'hbc,
    parameter logic [7:0]  SKP          = 8'h1c,
    parameter logic [7:0]  STP          = 8'hfb,
    parameter logic [7:0]  SDP          = 8'h5c,
    parameter logic [7:0]  END          = 8'hfd,
    parameter logic [7:0]  IDL          = 8'h7c
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic       tlp_valid,
    input  logic [7:0] tlp_data,
    input  logic       tlp_last,
    output logic       tlp_ready,
    input  logic       dllp_valid,
    input  logic [7:0] dllp_data,
    input  logic       dllp_last,
    output logic       dllp_ready,
    output logic       valid,
    output logic [7:0] data,
    output logic       err_underrun
);

    localparam int unsigned CW = $clog2(SKP_INTERVAL + 1);
    localparam logic [CW-1:0] SKP_MAX = CW'(SKP_INTERVAL);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_PAYLOAD,
        ST_OS
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    sub_q, sub_d;       // COM count in INIT, SKP count in OS
    logic          grant_q, grant_d;   // 0 = TLP, 1 = DLLP
    logic          prio_q, prio_d;     // source that wins a tie
    logic          eop_q, eop_d;       // last byte taken, END due next
    logic [CW-1:0] skp_cnt_q, skp_cnt_d;
    logic          valid_q, valid_d;
    logic [7:0]    data_q, data_d;
    logic          err_q, err_d;
    logic          tlp_ready_q, tlp_ready_d;
    logic          dllp_ready_q, dllp_ready_d;

    logic          skp_pending;
    logic          src_valid;
    logic [7:0]    src_data;
    logic          src_last;
    logic          pick_dllp;

    assign skp_pending = (skp_cnt_q == SKP_MAX);
    assign src_valid   = grant_q ? dllp_valid : tlp_valid;
    assign src_data    = grant_q ? dllp_data  : tlp_data;
    assign src_last    = grant_q ? dllp_last  : tlp_last;
    // Lone requester wins; on a tie the priority pointer decides.
    assign pick_dllp   = dllp_valid && (!tlp_valid || prio_q);

    always_comb begin
        state_d      = state_q;
        sub_d        = sub_q;
        grant_d      = grant_q;
        prio_d       = prio_q;
        eop_d        = eop_q;
        valid_d      = 1'b1;
        data_d       = data_q;
        err_d        = 1'b0;
        tlp_ready_d  = tlp_ready_q;
        dllp_ready_d = dllp_ready_q;

        // Saturating count of emitted symbols since the last ordered set.
        skp_cnt_d = skp_cnt_q;
        if (valid_q && !skp_pending) begin
            skp_cnt_d = skp_cnt_q + 1'b1;
        end

        unique case (state_q)
            ST_INIT: begin
                data_d    = COM;
                skp_cnt_d = '0;
                sub_d     = sub_q + 2'd1;
                if (sub_q == 2'd3) begin
                    sub_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (skp_pending) begin
                    data_d    = COM;
                    skp_cnt_d = '0;
                    sub_d     = '0;
                    state_d   = ST_OS;
                end else if (tlp_valid || dllp_valid) begin
                    grant_d      = pick_dllp;
                    data_d       = pick_dllp ? SDP : STP;
                    eop_d        = 1'b0;
                    tlp_ready_d  = !pick_dllp;
                    dllp_ready_d = pick_dllp;
                    state_d      = ST_PAYLOAD;
                end else begin
                    data_d = IDL;
                end
            end

            ST_PAYLOAD: begin
                if (eop_q) begin
                    data_d  = END;
                    eop_d   = 1'b0;
                    prio_d  = !grant_q;
                    state_d = ST_IDLE;
                end else if (src_valid) begin
                    // Ready is always high here, so valid alone is the handshake.
                    data_d = src_data;
                    if (src_last) begin
                        eop_d        = 1'b1;
                        tlp_ready_d  = 1'b0;
                        dllp_ready_d = 1'b0;
                    end
                end else begin
                    data_d       = END;
                    err_d        = 1'b1;
                    tlp_ready_d  = 1'b0;
                    dllp_ready_d = 1'b0;
                    prio_d       = !grant_q;
                    state_d      = ST_IDLE;
                end
            end

            ST_OS: begin
                data_d = SKP;
                sub_d  = sub_q + 2'd1;
                if (sub_q == 2'd2) begin
                    sub_d   = '0;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= ST_INIT;
            sub_q        <= '0;
            grant_q      <= 1'b0;
            prio_q       <= 1'b0;
            eop_q        <= 1'b0;
            skp_cnt_q    <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            err_q        <= 1'b0;
            tlp_ready_q  <= 1'b0;
            dllp_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sub_q        <= sub_d;
            grant_q      <= grant_d;
            prio_q       <= prio_d;
            eop_q        <= eop_d;
            skp_cnt_q    <= skp_cnt_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            err_q        <= err_d;
            tlp_ready_q  <= tlp_ready_d;
            dllp_ready_q <= dllp_ready_d;
        end
    end

    assign valid        = valid_q;
    assign data         = data_q;
    assign err_underrun = err_q;
    assign tlp_ready    = tlp_ready_q;
    assign dllp_ready   = dllp_ready_q;

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tx_symbol_scheduler
//
// Drives packets from two source queues and compares every output symbol with
// a symbol-stream model built from the framing rules: per decision point the
// model appends either an ordered set, a whole framed packet, or one IDL.
// -----------------------------------------------------------------------------
module tb_tx_symbol_scheduler;

    localparam int unsigned SI = 8;
    localparam logic [7:0] K_COM = 8'hbc;
    localparam logic [7:0] K_SKP = 8'h1c;
    localparam logic [7:0] K_STP = 8'hfb;
    localparam logic [7:0] K_SDP = 8'h5c;
    localparam logic [7:0] K_END = 8'hfd;
    localparam logic [7:0] K_IDL = 8'h7c;

    logic       clk = 1'b0;
    logic       reset_L;
    logic       tlp_valid, tlp_last, tlp_ready;
    logic [7:0] tlp_data;
    logic       dllp_valid, dllp_last, dllp_ready;
    logic [7:0] dllp_data;
    logic       valid;
    logic [7:0] data;
    logic       err_underrun;

    always #5 clk = ~clk;

    logic [1:0] sv, sl;
    logic [7:0] sd [2];

    assign tlp_valid  = sv[0];
    assign tlp_last   = sl[0];
    assign tlp_data   = sd[0];
    assign dllp_valid = sv[1];
    assign dllp_last  = sl[1];
    assign dllp_data  = sd[1];

    tx_symbol_scheduler #(
        .SKP_INTERVAL(SI)
    ) dut (
        .clk          (clk),
        .reset_L      (reset_L),
        .tlp_valid    (tlp_valid),
        .tlp_data     (tlp_data),
        .tlp_last     (tlp_last),
        .tlp_ready    (tlp_ready),
        .dllp_valid   (dllp_valid),
        .dllp_data    (dllp_data),
        .dllp_last    (dllp_last),
        .dllp_ready   (dllp_ready),
        .valid        (valid),
        .data         (data),
        .err_underrun (err_underrun)
    );

    typedef struct {
        int unsigned len;
        int unsigned drop;   // 0 = complete packet, else bytes sent before valid drops
        int unsigned gap;    // idle cycles before the packet is offered
        logic [7:0]  b [16];
    } pkt_t;

    typedef struct {
        logic [7:0] sym;
        logic       err;
        logic       com_rst; // COM that restarts the SKP interval
    } sym_t;

    pkt_t        pk [2][256];
    logic [7:0]  hd [2];
    logic [7:0]  tl [2];
    int unsigned idx [2];
    int unsigned waitc [2];
    logic [1:0]  dropped;
    logic [1:0]  acc;

    sym_t        exp_q [$];
    sym_t        cur;
    int unsigned since;
    logic        prio;

    int unsigned n_err = 0;
    int unsigned n_chk = 0;
    int unsigned tready_cnt;
    int unsigned err_cnt;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_sym(input logic [7:0] s, input logic e, input logic c);
        sym_t x;
        x.sym     = s;
        x.err     = e;
        x.com_rst = c;
        exp_q.push_back(x);
    endtask

    task automatic push_pkt(input int s, input int unsigned len, input int unsigned drop,
                            input int unsigned gap, input logic [7:0] base, input bit rnd);
        pkt_t p;
        p.len  = len;
        p.drop = drop;
        p.gap  = gap;
        for (int unsigned i = 0; i < 16; i++) begin
            p.b[i] = rnd ? 8'($urandom) : 8'(base + i);
        end
        pk[s][tl[s]] = p;
        tl[s]        = tl[s] + 8'd1;
    endtask

    // Advance each source after an edge (edge=1), then present its current byte.
    task automatic drive_update(input bit edge_seen);
        for (int s = 0; s < 2; s++) begin
            bit active;
            if (edge_seen && hd[s] != tl[s]) begin
                if (dropped[s]) begin
                    dropped[s] = 1'b0;
                    hd[s]      = hd[s] + 8'd1;
                    idx[s]     = 0;
                    waitc[s]   = 0;
                end else if (acc[s]) begin
                    idx[s]++;
                    if (idx[s] == pk[s][hd[s]].len) begin
                        hd[s]    = hd[s] + 8'd1;
                        idx[s]   = 0;
                        waitc[s] = 0;
                    end else if (idx[s] == pk[s][hd[s]].drop) begin
                        dropped[s] = 1'b1;
                    end
                end
            end
            active = (hd[s] != tl[s]) && !dropped[s] && (waitc[s] >= pk[s][hd[s]].gap);
            if (edge_seen && hd[s] != tl[s] && waitc[s] < pk[s][hd[s]].gap) begin
                waitc[s]++;
            end
            sv[s] = active;
            sd[s] = active ? pk[s][hd[s]].b[idx[s]] : 8'h00;
            sl[s] = active && (idx[s] == pk[s][hd[s]].len - 1);
        end
        acc = 2'b00;
    endtask

    // Expected symbol for the coming edge, built from the framing rules.
    task automatic model_step();
        if (exp_q.size() == 0) begin
            if (since >= SI) begin
                push_sym(K_COM, 1'b0, 1'b1);
                repeat (3) push_sym(K_SKP, 1'b0, 1'b0);
            end else if (sv != 2'b00) begin
                int s;
                int unsigned n;
                s = (sv == 2'b11) ? int'(prio) : (sv[1] ? 1 : 0);
                n = (pk[s][hd[s]].drop != 0) ? pk[s][hd[s]].drop : pk[s][hd[s]].len;
                push_sym((s == 1) ? K_SDP : K_STP, 1'b0, 1'b0);
                for (int unsigned i = 0; i < n; i++) begin
                    push_sym(pk[s][hd[s]].b[i], 1'b0, 1'b0);
                end
                push_sym(K_END, pk[s][hd[s]].drop != 0, 1'b0);
                prio = (s == 0);
            end else begin
                push_sym(K_IDL, 1'b0, 1'b0);
            end
        end
        cur   = exp_q.pop_front();
        since = cur.com_rst ? 0 : since + 1;
    endtask

    task automatic cycle();
        @(negedge clk);
        acc[0] = sv[0] && tlp_ready;
        acc[1] = sv[1] && dllp_ready;
        model_step();
        @(posedge clk);
        #1;
        check_eq("data", data, cur.sym);
        check_eq("valid", valid, 1);
        check_eq("err_underrun", err_underrun, cur.err);
        check_eq("ready_exclusive", tlp_ready & dllp_ready, 0);
        if (tlp_ready) tready_cnt++;
        if (err_underrun) err_cnt++;
        drive_update(1'b1);
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        #1;
        check_eq("rst_valid", valid, 0);
        check_eq("rst_data", data, 0);
        check_eq("rst_err", err_underrun, 0);
        check_eq("rst_tlp_ready", tlp_ready, 0);
        check_eq("rst_dllp_ready", dllp_ready, 0);
        for (int s = 0; s < 2; s++) begin
            hd[s] = 0; tl[s] = 0; idx[s] = 0; waitc[s] = 0;
            sv[s] = 1'b0; sl[s] = 1'b0; sd[s] = 8'h00;
        end
        dropped = 2'b00;
        acc     = 2'b00;
        exp_q.delete();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_eq("rst_hold_valid", valid, 0);
            check_eq("rst_hold_data", data, 0);
        end
        @(posedge clk);
        #2;
        repeat (4) push_sym(K_COM, 1'b0, 1'b1);
        since   = 0;
        prio    = 1'b0;
        reset_L = 1'b1;
    endtask

    task automatic run_drain(input int unsigned max_cycles);
        int unsigned n;
        bit drained;
        n = 0;
        while ((hd[0] != tl[0] || hd[1] != tl[1] || exp_q.size() != 0) && n < max_cycles) begin
            cycle();
            n++;
        end
        drained = (hd[0] == tl[0]) && (hd[1] == tl[1]) && (exp_q.size() == 0);
        check_eq("drain", drained, 1);
    endtask

    initial begin
        reset_L = 1'b0;
        sv = 2'b00; sl = 2'b00; sd[0] = 8'h00; sd[1] = 8'h00;
        #3;

        // Start-up with no requests: COM x4, then fill and ordered sets.
        do_reset();
        repeat (24) cycle();

        // Single 2-byte TLP offered straight out of reset.
        do_reset();
        push_pkt(0, 2, 0, 0, 8'h01, 1'b0);
        drive_update(1'b0);
        tready_cnt = 0;
        run_drain(60);
        repeat (4) cycle();
        check_eq("tlp_ready_cycles", tready_cnt, 2);

        // Both sources together, twice.
        repeat (2) begin
            push_pkt(0, 2, 0, 0, 8'h03, 1'b0);
            push_pkt(1, 2, 0, 0, 8'h0d, 1'b0);
            drive_update(1'b0);
            run_drain(80);
        end

        // Long TLP spanning the SKP interval.
        push_pkt(0, 12, 0, 0, 8'h00, 1'b1);
        drive_update(1'b0);
        run_drain(80);
        repeat (12) cycle();

        // Underrun after the first byte.
        err_cnt = 0;
        push_pkt(0, 2, 1, 0, 8'h01, 1'b0);
        drive_update(1'b0);
        run_drain(60);
        repeat (3) cycle();
        check_eq("err_pulses", err_cnt, 1);
        check_eq("tlp_ready_after_underrun", tlp_ready, 0);

        // Reset in the middle of a payload, then check TLP priority is back.
        push_pkt(0, 12, 0, 0, 8'h00, 1'b1);
        drive_update(1'b0);
        tready_cnt = 0;
        for (int i = 0; i < 40 && tready_cnt < 3; i++) cycle();
        check_eq("reached_payload", tready_cnt >= 3, 1);
        do_reset();
        push_pkt(1, 2, 0, 0, 8'h0d, 1'b0);
        push_pkt(0, 2, 0, 0, 8'h03, 1'b0);
        drive_update(1'b0);
        run_drain(80);

        // Randomized traffic with gaps, ties and underruns.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) begin
                int s;
                int unsigned len, drop;
                s = int'($urandom_range(1));
                if (8'(tl[s] - hd[s]) < 8'd8) begin
                    len  = $urandom_range(12, 1);
                    drop = (len >= 2 && $urandom_range(7) == 0) ? $urandom_range(len - 1, 1) : 0;
                    push_pkt(s, len, drop, $urandom_range(3), 8'h00, 1'b1);
                end
            end
            if (i == 1500) begin
                do_reset();
            end
            cycle();
        end
        run_drain(400);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
